// File: rtl/bcd_conv_pkg.sv
// Shared constants for the serial BCD <-> Excess-3 converter: mode encoding and
// default parameter values.
package bcd_conv_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    localparam int unsigned DIGIT_W_DEF   = 4;
    localparam int unsigned OFFSET_DEF    = 3;
    localparam int unsigned MAX_DIGIT_DEF = 9;

endpackage

// File: rtl/bcd_serial_range_chk.sv
// Range checker for one serial digit: collects the bits of the digit and raises a
// one-cycle registered err pulse when the completed source digit is out of range.
module bcd_serial_range_chk
    import bcd_conv_pkg::*;
#(
    parameter int unsigned DIGIT_W   = DIGIT_W_DEF,
    parameter int unsigned OFFSET    = OFFSET_DEF,
    parameter int unsigned MAX_DIGIT = MAX_DIGIT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic ser_bit,
    input  logic valid,
    input  logic last,
    input  logic mode,
    output logic err
);

    // The earlier DIGIT_W-1 bits are registered; the live bit completes the
    // DIGIT_W-bit window on the last bit.
    logic [DIGIT_W-2:0] sr_q;
    logic [DIGIT_W-2:0] sr_d;
    logic [DIGIT_W-1:0] digit_val;
    logic [31:0]        digit_ext;
    logic               illegal;
    logic               err_q;
    logic               err_d;

    always_comb begin
        sr_d      = sr_q;
        digit_val = {ser_bit, sr_q};
        digit_ext = 32'(digit_val);
        illegal   = 1'b0;
        err_d     = 1'b0;
        if (valid) begin
            sr_d = digit_val[DIGIT_W-1:1];
        end
        if (mode == MODE_ADD) begin
            illegal = digit_ext > MAX_DIGIT;
        end else begin
            illegal = (digit_ext < OFFSET) || (digit_ext > MAX_DIGIT + OFFSET);
        end
        err_d = valid & last & illegal;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/bcd_serial_converter.sv
// Bit-serial (LSB first) BCD <-> Excess-3 converter: adds or subtracts OFFSET per digit.
// Optional range checker enabled by macro BCD_SERIAL_CONV_ERRCHK_EN.
module bcd_serial_converter
    import bcd_conv_pkg::*;
#(
    parameter int unsigned DIGIT_W   = DIGIT_W_DEF,
    parameter int unsigned OFFSET    = OFFSET_DEF,
    parameter int unsigned MAX_DIGIT = MAX_DIGIT_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic x_in,
    input  logic x_valid,
    input  logic mode,
    output logic y_out,
    output logic y_valid,
    output logic digit_last,
    output logic err
);

    localparam int unsigned CNT_W = $clog2(DIGIT_W);
    localparam logic [DIGIT_W-1:0] OFF_BITS = DIGIT_W'(OFFSET);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DIGIT_W - 1);

    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             carry_q, carry_d;
    logic             mode_q, mode_d;
    logic             first_bit;
    logic             last_bit;
    logic             mode_eff;
    logic             k;
    logic             c;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        carry_d   = carry_q;
        mode_d    = mode_q;
        first_bit = (bit_cnt_q == '0);
        last_bit  = (bit_cnt_q == CNT_LAST);
        mode_eff  = first_bit ? mode : mode_q;
        // Subtraction is addition of the one's complement with carry-in 1.
        k         = OFF_BITS[bit_cnt_q] ^ (mode_eff == MODE_SUB);
        c         = first_bit ? (mode_eff == MODE_SUB) : carry_q;
        y_out     = x_in ^ k ^ c;
        if (x_valid) begin
            if (first_bit) begin
                mode_d = mode;
            end
            if (last_bit) begin
                bit_cnt_d = '0;
                carry_d   = 1'b0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                carry_d   = (x_in & k) | (x_in & c) | (k & c);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            carry_q   <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            carry_q   <= carry_d;
            mode_q    <= mode_d;
        end
    end

    assign y_valid    = x_valid;
    assign digit_last = x_valid & last_bit;

`ifdef BCD_SERIAL_CONV_ERRCHK_EN
    bcd_serial_range_chk #(
        .DIGIT_W   (DIGIT_W),
        .OFFSET    (OFFSET),
        .MAX_DIGIT (MAX_DIGIT)
    ) u_range_chk (
        .clock   (clock),
        .reset   (reset),
        .ser_bit (x_in),
        .valid   (x_valid),
        .last    (last_bit),
        .mode    (mode_eff),
        .err     (err)
    );
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/bcd_serial_converter.md
BCD_SERIAL_CONVERTER -- requirements
Module: bcd_serial_converter

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 4, giving the bits per serial digit (range 2..8).
REQ-002 The block SHALL have parameter OFFSET, default 3, giving the constant added or subtracted per digit (0..2^DIGIT_W-1).
REQ-003 The block SHALL have parameter MAX_DIGIT, default 9, giving the largest legal source-code digit value.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, reset that is asynchronous and active-high.
REQ-006 The block SHALL have port x_in, input, 1, the serial digit bit, LSB first.
REQ-007 The block SHALL have port x_valid, input, 1, which qualifies x_in; a bit is consumed only on clock edges where x_valid=1.
REQ-008 The block SHALL have port mode, input, 1: 0 = add OFFSET (BCD->Excess-3), 1 = subtract OFFSET (Excess-3->BCD).
REQ-009 The block SHALL have port y_out, output, 1, the converted serial bit (Mealy output, same cycle as x_in).
REQ-010 The block SHALL have port y_valid, output, 1, equal to x_valid (combinational).
REQ-011 The block SHALL have port digit_last, output, 1, high while the consumed bit is bit DIGIT_W-1 of a digit.
REQ-012 The block SHALL have port err, output, 1, a registered one-cycle pulse flagging an out-of-range source digit.

Function
REQ-013 The block SHALL hold its state as {bit_cnt[clog2(DIGIT_W)-1:0], carry, mode_q}, with bit_cnt=0 meaning the first bit of a digit.
REQ-014 At bit_cnt=0, the block SHALL use the live mode input and SHALL latch it into mode_q; for bits 1..DIGIT_W-1 it SHALL use mode_q, so a mid-digit mode change has no effect until the next digit.
REQ-015 The effective constant bit k SHALL be OFFSET[bit_cnt] for mode 0 and ~OFFSET[bit_cnt] for mode 1; the carry-in at bit 0 SHALL be 0 for mode 0 and 1 for mode 1.
REQ-016 y_out SHALL be x_in ^ k ^ c, where c is the carry-in at bit 0 and the stored carry otherwise; the next carry SHALL be majority(x_in, k, c).
REQ-017 Results SHALL wrap modulo 2^DIGIT_W; the carry out of bit DIGIT_W-1 SHALL be discarded and carry SHALL be cleared for the next digit.
REQ-018 On a consumed bit, bit_cnt SHALL increment, wrapping from DIGIT_W-1 to 0.
REQ-019 With x_valid=0, bit_cnt, carry and mode_q SHALL hold; y_out is don't-care; y_valid and digit_last SHALL be 0.
REQ-020 The source digit SHALL be legal when its value is in 0..MAX_DIGIT for mode 0, or in OFFSET..MAX_DIGIT+OFFSET for mode 1.
REQ-021 err SHALL pulse high for exactly one cycle on the clock edge after the last bit of an illegal digit is consumed; otherwise err SHALL be 0.
REQ-022 Conversion SHALL continue unaffected while err is asserted; there is no zero-latency gap between digits.

Reset
REQ-023 While reset=1, bit_cnt, carry, mode_q, the range-check shift register and err SHALL be 0.
REQ-024 Reset asserted mid-digit SHALL discard the partial digit; the first consumed bit after release SHALL be bit 0 of a new digit.

Configuration
REQ-025 With macro BCD_SERIAL_CONV_ERRCHK_EN defined, the range checker (DIGIT_W-bit shift register plus compare) and err behaviour of REQ-020/021 SHALL be present.
REQ-026 Without BCD_SERIAL_CONV_ERRCHK_EN, the checker logic SHALL be absent and err SHALL be tied to 0; all other behaviour SHALL be identical.

Structure
REQ-027 Package bcd_conv_pkg SHALL hold the mode encoding constants (MODE_ADD=0, MODE_SUB=1) and the default parameter values.
REQ-028 The range check SHALL be a sub-module bcd_serial_range_chk (inputs: bit, valid, last, mode; output: err) instantiated only under the macro.

Verification
REQ-029 mode=0, digit 0 (x_in 0,0,0,0) -> y_out 1,1,0,0 (value 3); digit_last only on the 4th bit; err=0.
REQ-030 mode=0, digit 5 (bits 1,0,1,0) -> y_out 0,0,0,1 (8); digit 9 (1,0,0,1) -> 0,0,1,1 (12), back-to-back with no gap.
REQ-031 mode=1, digit 8 (0,0,0,1) -> y_out 1,0,1,0 (5); mode=1, digit 1 (1,0,0,0) -> y_out 0,1,1,1 (14 wrap) and err pulse one cycle after the 4th bit.
REQ-032 mode=0, digit 12 (0,0,1,1) -> y_out 1,1,1,1 (15) and err pulse one cycle after the last bit; with the macro undefined -> err stays 0.
REQ-033 mode=0, digit 5 with x_valid=0 for 3 cycles after bit 1 and mode toggled to 1 during the stall -> output 0,0,0,1 unchanged; the next digit uses mode 1.
REQ-034 Reset pulse after 2 bits of a digit, then digit 0 -> y_out 1,1,0,0 and no err; a DIGIT_W=8, OFFSET=51 instance with input 0x12 -> output 0x45.
